// File: rtl/link_pkg.sv
// link_pkg: shared types and helpers for the round-robin link arbiter.
// Provides the FSM state enum, default byte width and a clog2 helper.
package link_pkg;

  localparam int DEF_DATA_W = 8;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SEND,
    ST_DROP,
    ST_DONE,
    ST_ABORT
  } state_e;

  // Ceiling log2, never below 1 so every counter keeps at least one bit.
  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < v) r = i + 1;
    end
    return (r < 1) ? 1 : r;
  endfunction

endpackage

// File: rtl/link_arbiter_rr_pick.sv
// rr_pick: combinational round-robin selector.
// Ports: req_i request vector, ptr_i start index; valid_o any request, idx_o winner.
module rr_pick
  import link_pkg::*;
#(
  parameter int N  = 4,
  parameter int IW = clog2(N)
) (
  input  logic [N-1:0]  req_i,
  input  logic [IW-1:0] ptr_i,
  output logic          valid_o,
  output logic [IW-1:0] idx_o
);

  function automatic logic [IW-1:0] wrap(input int v);
    return IW'(v % N);
  endfunction

  // Scan downward so the lowest offset from ptr_i is written last and wins.
  always_comb begin
    valid_o = 1'b0;
    idx_o   = '0;
    for (int k = N - 1; k >= 0; k--) begin
      if (req_i[wrap(int'(ptr_i) + k)]) begin
        valid_o = 1'b1;
        idx_o   = wrap(int'(ptr_i) + k);
      end
    end
  end

endmodule

// File: rtl/link_arbiter.sv
// link_arbiter: round-robin share of one 4-phase req/ack byte link.
// Ports: cl_req/cl_word in, cl_grant/cl_done/cl_err out, link_req/data/ack, busy.
module link_arbiter
  import link_pkg::*;
#(
  parameter int NUM_CLIENTS    = 4,
  parameter int BYTES_PER_XFER = 4,
  parameter int DATA_W         = DEF_DATA_W,
  parameter int TIMEOUT        = 64
) (
  input  logic                                      clk,
  input  logic                                      rst,
  input  logic [NUM_CLIENTS-1:0]                    cl_req,
  input  logic [NUM_CLIENTS*BYTES_PER_XFER*DATA_W-1:0] cl_word,
  output logic [NUM_CLIENTS-1:0]                    cl_grant,
  output logic [NUM_CLIENTS-1:0]                    cl_done,
  output logic [NUM_CLIENTS-1:0]                    cl_err,
  output logic                                      link_req,
  output logic [DATA_W-1:0]                         link_data,
  input  logic                                      link_ack,
  output logic                                      busy
);

  localparam int IW = clog2(NUM_CLIENTS);
  localparam int BW = clog2(BYTES_PER_XFER);
  localparam int TW = clog2(TIMEOUT + 1);
  localparam int WW = BYTES_PER_XFER * DATA_W;

  state_e        state_q, state_d;
  logic [IW-1:0] rr_q, rr_d;
  logic [IW-1:0] win_q, win_d;
  logic [BW-1:0] bidx_q, bidx_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic [WW-1:0] word_q, word_d;

  logic          pick_vld;
  logic [IW-1:0] pick_idx;

  rr_pick #(
    .N  (NUM_CLIENTS),
    .IW (IW)
  ) u_pick (
    .req_i   (cl_req),
    .ptr_i   (rr_q),
    .valid_o (pick_vld),
    .idx_o   (pick_idx)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      rr_q    <= '0;
      win_q   <= '0;
      bidx_q  <= '0;
      tmo_q   <= '0;
      word_q  <= '0;
    end else begin
      state_q <= state_d;
      rr_q    <= rr_d;
      win_q   <= win_d;
      bidx_q  <= bidx_d;
      tmo_q   <= tmo_d;
      word_q  <= word_d;
    end
  end

  always_comb begin
    state_d = state_q;
    rr_d    = rr_q;
    win_d   = win_q;
    bidx_d  = bidx_q;
    tmo_d   = tmo_q;
    word_d  = word_q;
    unique case (state_q)
      ST_IDLE: begin
        if (pick_vld) begin
          win_d   = pick_idx;
          word_d  = cl_word[pick_idx*WW +: WW];
          bidx_d  = '0;
          tmo_d   = '0;
          state_d = ST_SEND;
        end
      end
      ST_SEND: begin
        // An ack already high on entry counts as the ack.
        if (link_ack) begin
          state_d = ST_DROP;
        end else if (TIMEOUT != 0 &&
                     tmo_q == TW'(TIMEOUT - 1)) begin
          state_d = ST_ABORT;
        end else begin
          tmo_d = tmo_q + 1'b1;
        end
      end
      ST_DROP: begin
        if (!link_ack) begin
          if (bidx_q == BW'(BYTES_PER_XFER - 1)) begin
            state_d = ST_DONE;
          end else begin
            bidx_d  = bidx_q + 1'b1;
            tmo_d   = '0;
            state_d = ST_SEND;
          end
        end
      end
      ST_DONE, ST_ABORT: begin
        rr_d = (win_q == IW'(NUM_CLIENTS - 1)) ?
               '0 : win_q + 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    cl_grant  = '0;
    cl_done   = '0;
    cl_err    = '0;
    link_req  = (state_q == ST_SEND);
    busy      = (state_q != ST_IDLE);
    // byte index only moves on DROP->SEND, so data holds through DROP.
    link_data = word_q[bidx_q*DATA_W +: DATA_W];
    unique case (state_q)
      ST_SEND,
      ST_DROP:  cl_grant[win_q] = 1'b1;
      ST_DONE:  cl_done[win_q]  = 1'b1;
      ST_ABORT: cl_err[win_q]   = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: doc/link_arbiter.md
Name: link_arbiter

Overview:
- Shares one 4-phase req/ack byte link between NUM_CLIENTS requesters.
- Each client presents a BYTES_PER_XFER-byte word. The arbiter picks one client round-robin, latches its word, and serialises it LSB-byte-first over the link.
- Reports per-client completion (done) or abort on ack timeout (err).
- Sits between the client FSMs and the shared link slave, replacing direct per-master link drivers.

Parameters:
NUM_CLIENTS, 4, number of requesters (2..8)
BYTES_PER_XFER, 4, bytes per transfer (1..8)
DATA_W, 8, link byte width
TIMEOUT, 64, max cycles in SEND waiting for ack; 0 disables timeout

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
cl_req  in  NUM_CLIENTS  per-client level request; held until that client's done or err
cl_word  in  NUM_CLIENTS*BYTES_PER_XFER*DATA_W  per-client payload; client i at slice i; byte 0 = LSBs
cl_grant  out  NUM_CLIENTS  one-hot, high for the whole transfer of the granted client
cl_done  out  NUM_CLIENTS  one-hot 1-cycle pulse, transfer completed
cl_err  out  NUM_CLIENTS  one-hot 1-cycle pulse, transfer aborted on timeout
link_req  out  1  4-phase request to slave
link_data  out  DATA_W  current byte; stable whenever link_req=1
link_ack  in  1  4-phase acknowledge from slave
busy  out  1  high in any state other than IDLE

Behaviour:
- Reset: state=IDLE, rr_ptr=0, byte_idx=0, tmo_cnt=0.
- Reset values of outputs: link_req=0, link_data=0, cl_grant=0, cl_done=0, cl_err=0, busy=0.
- Reset mid-transfer aborts immediately. No done/err pulse is issued; link_req is low the next cycle.
- All outputs are Moore outputs, decoded from registered state and latched registers.
- States: IDLE, SEND, DROP, DONE, ABORT.
- IDLE:
  - If any cl_req is high, the winner is the first requesting index at or after rr_ptr, scanning upward modulo NUM_CLIENTS.
  - Latch win_idx and the winner's cl_word; set byte_idx=0, tmo_cnt=0; go to SEND.
  - With no request, stay in IDLE.
- SEND:
  - link_req=1; link_data = latched byte[byte_idx]; cl_grant[win_idx]=1.
  - link_ack=1 -> go to DROP.
  - Otherwise, if TIMEOUT!=0 and tmo_cnt==TIMEOUT-1 -> go to ABORT; else tmo_cnt++.
- DROP:
  - link_req=0; link_data holds its value; cl_grant held.
  - Wait for link_ack=0, with no timeout.
  - On link_ack=0: if byte_idx==BYTES_PER_XFER-1 -> go to DONE; else byte_idx++, tmo_cnt=0, go to SEND.
- DONE: cl_done[win_idx]=1 for 1 cycle; rr_ptr=(win_idx+1) mod NUM_CLIENTS; go to IDLE.
- ABORT: cl_err[win_idx]=1 for 1 cycle; link_req=0; rr_ptr advances as in DONE; go to IDLE.
- Latency:
  - cl_req to link_req: 1 cycle.
  - Each byte takes a minimum of 2 cycles (SEND, DROP) when the slave acks immediately.
  - Back-to-back transfers have a minimum 1-cycle IDLE gap after DONE/ABORT.
- Boundary conditions:
  - Client deasserts cl_req mid-transfer: ignored; the latched word completes and done still pulses.
  - cl_word changes mid-transfer: ignored, because the word is latched at grant.
  - link_ack already high on entry to SEND (slave misbehaviour): treated as the ack; go to DROP.
  - rr_ptr wraps from NUM_CLIENTS-1 to 0.
  - A single requester is re-granted on every arbitration.
- Width rules:
  - byte_idx width is clog2(BYTES_PER_XFER), minimum 1.
  - tmo_cnt width is clog2(TIMEOUT+1).
  - rr_ptr and win_idx width is clog2(NUM_CLIENTS).

Decomposition:
- Shared package link_pkg:
  - state enum (IDLE, SEND, DROP, DONE, ABORT);
  - DATA_W default;
  - clog2 helper function.
- One sub-module, rr_pick: combinational round-robin priority selector. Inputs are the request vector and rr_ptr; outputs are a valid flag and the winner index.
- The FSM, counters and datapath latch stay in link_arbiter.

Test Plan:
- Client 0 only, cl_word=0xDDCCBBAA; slave acks 2 cycles after req and drops ack 1 cycle after req falls -> link_data sequence AA,BB,CC,DD; exactly 4 req pulses; one cl_done[0] pulse; busy low afterwards.
- All 4 clients hold cl_req continuously, zero-latency slave -> grant order 0,1,2,3,0,1. Each cl_done is one-hot and matches the preceding grant; IDLE gap of exactly 1 cycle.
- TIMEOUT=16, client 2 requests, slave never acks -> link_req high exactly 16 cycles; cl_err[2] pulses; no cl_done. Client 3, also pending, is granted next.
- Client 1 drops cl_req and changes cl_word after byte 0 -> remaining bytes come from the original word; cl_done[1] still pulses.
- Slave holds link_ack high 20 cycles after byte 1 -> FSM stays in DROP with no err; byte 2 follows after ack falls.
- rst asserted during byte 2 of a transfer -> next cycle link_req=0, cl_grant=0, rr_ptr=0, no done/err; a fresh request then transfers from byte 0.
